// File: rtl/bound_search.sv
// bound_search: binary search of a latched target inside a [low, high] window, one probe per cycle.
// Latency: first guess is valid in the cycle after an accepted start; an N-probe search pulses done in cycle N+1.
// Backpressure: none; start is sampled only in IDLE and is dropped (not queued) while a search is in flight.
// Optional feature: define BOUND_SEARCH_ABORT_EN to add an abort input that cancels a search in GUESS.
module bound_search #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] target,
  input  logic [WIDTH-1:0] low_init,
  input  logic [WIDTH-1:0] high_init,
`ifdef BOUND_SEARCH_ABORT_EN
  input  logic             abort,
`endif
  output logic [WIDTH-1:0] guess,
  output logic [WIDTH-1:0] low,
  output logic [WIDTH-1:0] high,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic             error,
  output logic [WIDTH-1:0] steps
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GUESS = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] target_q;
  logic [WIDTH-1:0] guess_q;
  logic [WIDTH-1:0] probe;
  logic             abort_hit;

  // Midpoint taken as low + half the span so the sum never needs a carry bit.
  assign probe = low + ((high - low) >> 1);

  // While searching the probe is shown live; otherwise the last issued probe is held.
  assign guess = (state == GUESS) ? probe : guess_q;

`ifdef BOUND_SEARCH_ABORT_EN
  assign abort_hit = abort;
`else
  assign abort_hit = 1'b0;
`endif

  // Search FSM: latches the request, narrows the window each probe, and reports the outcome.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      target_q <= '0;
      guess_q  <= '0;
      low      <= '0;
      high     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      found    <= 1'b0;
      error    <= 1'b0;
      steps    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            target_q <= target;
            low      <= low_init;
            high     <= high_init;
            found    <= 1'b0;
            error    <= 1'b0;
            steps    <= '0;
            if (low_init > high_init) begin
              // Inverted window: report straight away without probing.
              error <= 1'b1;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              busy  <= 1'b1;
              state <= GUESS;
            end
          end
        end
        GUESS: begin
          steps   <= steps + 1'b1;
          guess_q <= probe;
          if (abort_hit) begin
            // Cancelled search leaves results as they stand, with no completion pulse.
            busy  <= 1'b0;
            state <= IDLE;
          end else if (probe == target_q) begin
            found <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else if ((probe < target_q) && (probe == high)) begin
            // Target lies above the window; stopping here keeps low from wrapping.
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else if ((probe > target_q) && (probe == low)) begin
            // Target lies below the window; stopping here keeps high from wrapping.
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else if (probe < target_q) begin
            low <= probe + 1'b1;
          end else begin
            high <= probe - 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
